// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - opcode codes, state encoding and byte helpers for mem_ctrl
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STORE = 3'd2,
        ST_FETCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    // Number of bytes moved by an opcode; anything unrecognised moves a word.
    function automatic logic [2:0] access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    // Sign/zero extension of an assembled little-endian load.
    function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [31:0] w);
        case (op)
            OP_LB:   return {{24{w[7]}}, w[7:0]};
            OP_LH:   return {{16{w[15]}}, w[15:0]};
            OP_LBU:  return {24'h0, w[7:0]};
            OP_LHU:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller for the LSB and fetch clients
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] IO_MASK = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              lsb_valid,
    input  logic              lsb_ls,
    input  logic [5:0]        lsb_opcode,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_data,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t state, state_n;

    // Latched request; k is the index of the byte currently on the bus.
    logic              cl_fetch, cl_fetch_n;
    logic [5:0]        cl_op, cl_op_n;
    logic [ADDR_W-1:0] cl_addr, cl_addr_n;
    logic [31:0]       cl_data, cl_data_n;
    logic [2:0]        cl_n, cl_n_n;
    logic [2:0]        k, k_n;
    logic [31:0]       rbuf, rbuf_n;

    logic [ADDR_W-1:0] mem_a_n;
    logic              mem_wr_n;
    logic [7:0]        mem_dout_n;
    logic              lsb_done_n, if_done_n;
    logic [31:0]       lsb_rdata_n, if_data_n;

    logic [2:0]        k_inc;
    logic              io_stall;
    logic [31:0]       word_cap;

    assign k_inc    = k + 3'd1;
    assign io_stall = (cl_addr[17:16] == IO_MASK) && io_buffer_full;
    // mem_din carries the byte whose address was on the bus one cycle earlier.
    assign word_cap = (k != 3'd0) ? byte_put(rbuf, k[1:0] - 2'd1, mem_din) : rbuf;

    // State register; rdy low freezes the machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= ST_IDLE;
        else if (rdy) state <= state_n;
    end

    // Next-state: LSB wins arbitration, flush only aborts fetches.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (lsb_valid)             state_n = lsb_ls ? ST_LOAD : ST_STORE;
                else if (if_valid && !flush) state_n = ST_FETCH;
            end
            ST_LOAD:  if (k == cl_n) state_n = ST_DONE;
            ST_FETCH: begin
                if (flush)          state_n = ST_IDLE;
                else if (k == cl_n) state_n = ST_DONE;
            end
            ST_STORE: if (mem_wr && (k == cl_n - 3'd1)) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Output/datapath next values; bus outputs default to idle zeros.
    always_comb begin
        k_n         = k;
        cl_fetch_n  = cl_fetch;
        cl_op_n     = cl_op;
        cl_addr_n   = cl_addr;
        cl_data_n   = cl_data;
        cl_n_n      = cl_n;
        rbuf_n      = rbuf;
        lsb_rdata_n = lsb_rdata;
        if_data_n   = if_data;
        mem_a_n     = '0;
        mem_wr_n    = 1'b0;
        mem_dout_n  = 8'h00;
        lsb_done_n  = 1'b0;
        if_done_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lsb_valid) begin
                    cl_fetch_n = 1'b0;
                    cl_op_n    = lsb_opcode;
                    cl_addr_n  = lsb_addr;
                    cl_data_n  = lsb_data;
                    cl_n_n     = access_size(lsb_opcode);
                    k_n        = 3'd0;
                    rbuf_n     = 32'h0;
                    mem_a_n    = lsb_addr;
                    if (!lsb_ls) begin
                        mem_dout_n = lsb_data[7:0];
                        mem_wr_n   = !((lsb_addr[17:16] == IO_MASK) && io_buffer_full);
                    end
                end else if (if_valid && !flush) begin
                    cl_fetch_n = 1'b1;
                    cl_op_n    = OP_LW;
                    cl_addr_n  = if_addr;
                    cl_n_n     = 3'd4;
                    k_n        = 3'd0;
                    rbuf_n     = 32'h0;
                    mem_a_n    = if_addr;
                end
            end
            ST_LOAD, ST_FETCH: begin
                if (state == ST_FETCH && flush) begin
                    k_n = 3'd0;
                end else begin
                    rbuf_n = word_cap;
                    if (k == cl_n) begin
                        k_n = 3'd0;
                        if (cl_fetch) begin
                            if_done_n = 1'b1;
                            if_data_n = word_cap;
                        end else begin
                            lsb_done_n  = 1'b1;
                            lsb_rdata_n = extend_load(cl_op, word_cap);
                        end
                    end else begin
                        k_n = k_inc;
                        if (k_inc < cl_n) mem_a_n = cl_addr + ADDR_W'(k_inc);
                    end
                end
            end
            ST_STORE: begin
                if (mem_wr) begin
                    if (k == cl_n - 3'd1) begin
                        k_n        = 3'd0;
                        lsb_done_n = 1'b1;
                    end else begin
                        k_n        = k_inc;
                        mem_a_n    = cl_addr + ADDR_W'(k_inc);
                        mem_dout_n = byte_sel(cl_data, k_inc[1:0]);
                        mem_wr_n   = !io_stall;
                    end
                end else begin
                    // Stalled on a full IO buffer: re-present the same byte.
                    mem_a_n    = cl_addr + ADDR_W'(k);
                    mem_dout_n = byte_sel(cl_data, k[1:0]);
                    mem_wr_n   = !io_stall;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs; all hold while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cl_fetch  <= 1'b0;
            cl_op     <= 6'd0;
            cl_addr   <= '0;
            cl_data   <= 32'h0;
            cl_n      <= 3'd0;
            k         <= 3'd0;
            rbuf      <= 32'h0;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
            mem_dout  <= 8'h00;
            lsb_done  <= 1'b0;
            if_done   <= 1'b0;
            lsb_rdata <= 32'h0;
            if_data   <= 32'h0;
        end else if (rdy) begin
            cl_fetch  <= cl_fetch_n;
            cl_op     <= cl_op_n;
            cl_addr   <= cl_addr_n;
            cl_data   <= cl_data_n;
            cl_n      <= cl_n_n;
            k         <= k_n;
            rbuf      <= rbuf_n;
            mem_a     <= mem_a_n;
            mem_wr    <= mem_wr_n;
            mem_dout  <= mem_dout_n;
            lsb_done  <= lsb_done_n;
            if_done   <= if_done_n;
            lsb_rdata <= lsb_rdata_n;
            if_data   <= if_data_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        lsb_valid, lsb_ls;
    logic [5:0]  lsb_opcode;
    logic [31:0] lsb_addr, lsb_data;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic        ls;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic [7:0]  ram [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    wr_t         wlog[$];
    wr_t         wtmp;
    logic [31:0] seen_a[$];
    vec_t        vt[12];
    logic [5:0]  ops[8];

    mem_ctrl #(.ADDR_W(32), .IO_MASK(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .lsb_valid(lsb_valid), .lsb_ls(lsb_ls), .lsb_opcode(lsb_opcode),
        .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    // RAM: one-cycle read latency, writes when mem_wr, gated by rdy.
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) begin
                ram[mem_a] = mem_dout;
                wtmp.a = mem_a;
                wtmp.d = mem_dout;
                wlog.push_back(wtmp);
            end
            mem_din <= ram_rd(mem_a);
        end
    end

    function automatic int size_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    // Reference load: little-endian sum of n bytes, then two's-complement fold for signed ops.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        longint v = 0;
        int     n = size_of(op);
        for (int j = 0; j < n; j++) v += longint'(ref_rd(a + 32'(j))) * (longint'(1) << (8 * j));
        if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        for (int j = 0; j < size_of(op); j++) ref_mem[a + 32'(j)] = 8'((d >> (8 * j)) & 32'hFF);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_writes(input string name, input logic [31:0] a, input logic [31:0] d,
                                input int n);
        check({name, "_count"}, 32'(wlog.size()), 32'(n));
        for (int j = 0; j < n && j < wlog.size(); j++) begin
            check({name, "_addr"}, wlog[j].a, a + 32'(j));
            check({name, "_byte"}, 32'(wlog[j].d), (d >> (8 * j)) & 32'hFF);
        end
    endtask

    task automatic check_addrs(input string name, input logic [31:0] a, input int n);
        for (int j = 0; j < n; j++)
            check(name, (j < seen_a.size()) ? seen_a[j] : 32'hxxxxxxxx, a + 32'(j));
    endtask

    // One LSB request; c = number of edges after the accept edge until lsb_done is seen.
    task automatic do_lsb(input logic ls, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got, output int c);
        @(negedge clk);
        seen_a.delete();
        wlog.delete();
        lsb_valid = 1'b1; lsb_ls = ls; lsb_opcode = op; lsb_addr = a; lsb_data = d;
        got = 32'h0;
        c   = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            seen_a.push_back(mem_a);
            if (lsb_done) begin got = lsb_rdata; c = i; break; end
        end
        lsb_valid = 1'b0;
        if (c < 0) begin
            checks++; errors++;
            $display("FAIL lsb_timeout got=none expected=lsb_done");
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] got, output int c);
        @(negedge clk);
        seen_a.delete();
        if_valid = 1'b1; if_addr = a;
        got = 32'h0;
        c   = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            seen_a.push_back(mem_a);
            if (if_done) begin got = if_data; c = i; break; end
        end
        if_valid = 1'b0;
        if (c < 0) begin
            checks++; errors++;
            $display("FAIL fetch_timeout got=none expected=if_done");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, got2, a, d, a1;
        int          c, lc, fc, n, hits;
        logic [5:0]  op;

        rst = 1'b1; rdy = 1'b1; lsb_valid = 1'b0; lsb_ls = 1'b0; lsb_opcode = 6'd0;
        lsb_addr = 32'h0; lsb_data = 32'h0; if_valid = 1'b0; if_addr = 32'h0;
        flush = 1'b0; io_buffer_full = 1'b0; mem_din = 8'h00;

        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h200, 8'h80);
        poke(32'h210, 8'h01); poke(32'h211, 8'h80);
        poke(32'h600, 8'h13);
        poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22);
        poke(32'h0, 8'h33); poke(32'h1, 8'h44);

        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        vt[0]  = '{1'b1, OP_LW,  32'h100,      32'h0,        32'h12345678, 5};
        vt[1]  = '{1'b1, OP_LB,  32'h200,      32'h0,        32'hFFFFFF80, 2};
        vt[2]  = '{1'b1, OP_LBU, 32'h200,      32'h0,        32'h00000080, 2};
        vt[3]  = '{1'b1, OP_LH,  32'h210,      32'h0,        32'hFFFF8001, 3};
        vt[4]  = '{1'b1, OP_LHU, 32'h210,      32'h0,        32'h00008001, 3};
        vt[5]  = '{1'b0, OP_SH,  32'h300,      32'h0000BEEF, 32'h0,        2};
        vt[6]  = '{1'b1, OP_LW,  32'h300,      32'h0,        32'h0000BEEF, 5};
        vt[7]  = '{1'b0, OP_SW,  32'h400,      32'hCAFEF00D, 32'h0,        4};
        vt[8]  = '{1'b1, OP_LH,  32'h402,      32'h0,        32'hFFFFCAFE, 3};
        vt[9]  = '{1'b0, OP_SB,  32'h404,      32'hFFFFFF7F, 32'h0,        1};
        vt[10] = '{1'b1, OP_LB,  32'h404,      32'h0,        32'h0000007F, 2};
        vt[11] = '{1'b1, OP_LW,  32'hFFFFFFFE, 32'h0,        32'h44332211, 5};

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_dones", {30'h0, lsb_done, if_done}, 32'h0);
        check("rst_lsb_rdata", lsb_rdata, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_lsb(vt[i].ls, vt[i].op, vt[i].addr, vt[i].data, got, c);
            check("tbl_latency", 32'(c), 32'(vt[i].lat));
            if (vt[i].ls) begin
                check("tbl_rdata", got, vt[i].exp);
                check_addrs("tbl_mem_a", vt[i].addr, size_of(vt[i].op));
            end else begin
                check_writes("tbl_store", vt[i].addr, vt[i].data, size_of(vt[i].op));
                ref_store(vt[i].op, vt[i].addr, vt[i].data);
            end
            @(negedge clk);
            check("tbl_done_pulse", 32'(lsb_done), 32'h0);
        end

        // IO store stalled for three cycles by a full buffer
        @(negedge clk);
        wlog.delete();
        io_buffer_full = 1'b1;
        lsb_valid = 1'b1; lsb_ls = 1'b0; lsb_opcode = OP_SB; lsb_addr = 32'h30000; lsb_data = 32'h41;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("io_stall_wr", 32'(mem_wr), 32'h0);
        end
        io_buffer_full = 1'b0;
        @(posedge clk); @(negedge clk);
        check("io_write_wr", 32'(mem_wr), 32'h1);
        check("io_write_a", mem_a, 32'h30000);
        check("io_write_byte", 32'(mem_dout), 32'h41);
        @(posedge clk); @(negedge clk);
        check("io_done", 32'(lsb_done), 32'h1);
        lsb_valid = 1'b0;
        check("io_write_count", 32'(wlog.size()), 32'h1);
        ref_store(OP_SB, 32'h30000, 32'h41);

        // rdy low for two cycles in the middle of a load
        @(negedge clk);
        lsb_valid = 1'b1; lsb_ls = 1'b1; lsb_opcode = OP_LW; lsb_addr = 32'h100;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        a1  = mem_a;
        rdy = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rdy_hold_a", mem_a, a1);
        @(posedge clk); @(negedge clk);
        rdy = 1'b1;
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (lsb_done) begin c = i + 4; got = lsb_rdata; break; end
        end
        lsb_valid = 1'b0;
        check("rdy_latency", 32'(c), 32'd7);
        check("rdy_rdata", got, 32'h12345678);

        // Simultaneous requests: LSB first, then the fetch
        @(negedge clk);
        lsb_valid = 1'b1; lsb_ls = 1'b1; lsb_opcode = OP_LW; lsb_addr = 32'h100;
        if_valid = 1'b1; if_addr = 32'h600;
        lc = -1; fc = -1; got = 32'h0; got2 = 32'h0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); @(negedge clk);
            if (lsb_done) begin lc = i; got = lsb_rdata; lsb_valid = 1'b0; end
            if (if_done) begin fc = i; got2 = if_data; if_valid = 1'b0; break; end
        end
        lsb_valid = 1'b0; if_valid = 1'b0;
        check("arb_lsb_latency", 32'(lc), 32'd5);
        check("arb_lsb_rdata", got, 32'h12345678);
        check("arb_fetch_cycle", 32'(fc), 32'd12);
        check("arb_fetch_data", got2, 32'h00000013);

        // Flush during the second fetch byte
        @(negedge clk);
        if_valid = 1'b1; if_addr = 32'h600;
        @(posedge clk); @(negedge clk);
        check("flush_first_a", mem_a, 32'h600);
        @(posedge clk); @(negedge clk);
        check("flush_second_a", mem_a, 32'h601);
        flush = 1'b1; if_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("flush_idle_a", mem_a, 32'h0);
        check("flush_idle_wr", 32'(mem_wr), 32'h0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            if (if_done) hits++;
            @(posedge clk); @(negedge clk);
        end
        check("flush_no_done", 32'(hits), 32'h0);

        // Asynchronous reset in the middle of a store
        @(negedge clk);
        lsb_valid = 1'b1; lsb_ls = 1'b0; lsb_opcode = OP_SW; lsb_addr = 32'h700; lsb_data = 32'hA5A5A5A5;
        @(posedge clk); @(negedge clk);
        check("mid_store_wr", 32'(mem_wr), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_wr", 32'(mem_wr), 32'h0);
        check("arst_mem_a", mem_a, 32'h0);
        check("arst_mem_dout", 32'(mem_dout), 32'h0);
        check("arst_lsb_rdata", lsb_rdata, 32'h0);
        @(negedge clk);
        lsb_valid = 1'b0;
        rst = 1'b0;
        do_lsb(1'b1, OP_LW, 32'h100, 32'h0, got, c);
        check("post_rst_latency", 32'(c), 32'd5);
        check("post_rst_rdata", got, 32'h12345678);

        // Randomised traffic against the reference memory
        for (int r = 0; r < 40; r++) begin
            a = 32'h1000 + 32'($urandom_range(0, 31));
            d = $urandom();
            if ($urandom_range(0, 9) < 2) begin
                a = a & ~32'h3;
                do_fetch(a, got, c);
                check("rnd_fetch_latency", 32'(c), 32'd5);
                check("rnd_fetch_data", got, ref_load(OP_LW, a));
            end else begin
                op = ops[$urandom_range(0, 7)];
                n  = size_of(op);
                if (is_load(op)) begin
                    do_lsb(1'b1, op, a, d, got, c);
                    check("rnd_load_latency", 32'(c), 32'(n + 1));
                    check("rnd_load_rdata", got, ref_load(op, a));
                end else begin
                    do_lsb(1'b0, op, a, d, got, c);
                    check("rnd_store_latency", 32'(c), 32'(n));
                    check_writes("rnd_store", a, d, n);
                    ref_store(op, a, d);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
